// File: rtl/regfile_dump_reader.sv
// Register file dump reader: walks an index range on read port 1
// and streams each captured word out on a valid/ready interface.
module regfile_dump_reader #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_index,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] end_idx_q, end_idx_d;
  logic [AW-1:0] rf_addr_q, rf_addr_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [AW-1:0] m_index_q, m_index_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state logic: walk the range, one READ/CAPTURE/SEND per word.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    end_idx_d = end_idx_q;
    rf_addr_d = rf_addr_q;
    m_data_d  = m_data_q;
    m_index_d = m_index_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (first_idx <= last_idx) begin
            idx_d     = first_idx;
            end_idx_d = last_idx;
            rf_addr_d = first_idx;
            busy_d    = 1'b1;
            state_d   = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        m_data_d  = rf_rd;
        m_index_d = idx_q;
        m_last_d  = (idx_q == end_idx_q);
        m_valid_d = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            m_last_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            idx_d     = idx_q + 1'b1;
            rf_addr_d = idx_q + 1'b1;
            state_d   = READ;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      end_idx_q <= '0;
      rf_addr_q <= '0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      end_idx_q <= end_idx_d;
      rf_addr_q <= rf_addr_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rf_addr = rf_addr_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_index = m_index_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader: register file model, beat
// monitor and a range-walk reference computed from a memory image.
module tb_regfile_dump_reader;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first_idx, last_idx, rf_addr, m_index;
  logic [DW-1:0] rf_rd, m_data;
  logic          m_valid, m_ready, m_last, busy, done;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] img [32];
  logic          fill = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;

  beat_t got [$];
  beat_t exp_q [$];
  int    done_cnt = 0;
  int    busy_cnt = 0;
  int    ecnt = 0;
  int    last_done_edge = -1;

  regfile_dump_reader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .first_idx(first_idx), .last_idx(last_idx),
    .rf_addr(rf_addr), .rf_rd(rf_rd),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file with one write port.
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    rf_rd <= mem[rf_addr];
    if (fill) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // Record every handshaked beat plus done/busy activity.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready)
      got.push_back({m_index, m_data, m_last});
    if (done) begin
      done_cnt++;
      last_done_edge = ecnt;
    end
    if (busy) busy_cnt++;
  end

  task automatic build_exp(input int f, input int l);
    beat_t b;
    exp_q.delete();
    for (int i = f; i <= l; i++) begin
      b.idx = AW'(i);
      b.data = img[i];
      b.last = (i == l);
      exp_q.push_back(b);
    end
  endtask

  task automatic load_rf();
    @(posedge clk); #1 fill = 1'b1;
    @(posedge clk); #1 fill = 1'b0;
  endtask

  task automatic do_start(input int f, input int l, output int n_edge);
    @(posedge clk); #1;
    start = 1'b1;
    first_idx = AW'(f);
    last_idx = AW'(l);
    @(posedge clk); #1;
    n_edge = ecnt;
    start = 1'b0;
    first_idx = AW'($urandom);
    last_idx = AW'($urandom);
  endtask

  task automatic run_until_done(input bit rnd, input int base_done);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt > base_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    m_ready = 1'b1;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout: no done within budget");
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    first_idx = '0;
    last_idx = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (rf_addr !== '0) begin
      n_fail++; $display("FAIL reset_rf_addr: got %0h want 0", rf_addr);
    end
    n_chk++;
    if ({m_valid, m_last, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {m_valid, m_last, busy, done});
    end
    n_chk++;
    if ({m_data, m_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h/%0h want 0/0", m_data, m_index);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_dump();
    int n, b0, d0;
    for (int i = 0; i < 32; i++) img[i] = DW'(i);
    load_rf();
    b0 = got.size();
    d0 = done_cnt;
    build_exp(0, 31);
    do_start(0, 31, n);
    run_until_done(1'b0, d0);
    n_chk++;
    if (got.size() - b0 != 32) begin
      n_fail++;
      $display("FAIL full_count: got %0d want 32", got.size() - b0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_chk++;
        if (got[b0+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL full_beat%0d: got %h want %h", i, got[b0+i], exp_q[i]);
        end
      end
    end
    n_chk++;
    if (last_done_edge != n + 96) begin
      n_fail++;
      $display("FAIL full_done_edge: got %0d want %0d", last_done_edge, n + 96);
    end
    n_chk++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL full_done_pulses: got %0d want 1", done_cnt - d0);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL full_busy_after: got %b want 0", busy);
    end
  endtask

  task automatic test_stall();
    int n, b0, d0, stable;
    bit seen = 1'b0;
    b0 = got.size();
    d0 = done_cnt;
    build_exp(0, 31);
    do_start(0, 31, n);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (m_valid && m_index == 5) seen = 1'b1;
    end
    m_ready = 1'b0;
    stable = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_valid === 1'b1 && m_data === img[5] && m_index === 5)
        stable++;
    end
    m_ready = 1'b1;
    n_chk++;
    if (!seen || stable != 10) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d stable cycles want 10", stable);
    end
    run_until_done(1'b0, d0);
    n_chk++;
    if (got.size() - b0 != 32) begin
      n_fail++;
      $display("FAIL stall_count: got %0d want 32", got.size() - b0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_chk++;
        if (got[b0+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %h want %h", i, got[b0+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ranges();
    int n, b0, d0, bz0;
    b0 = got.size();
    d0 = done_cnt;
    build_exp(3, 7);
    do_start(3, 7, n);
    run_until_done(1'b0, d0);
    n_chk++;
    if (got.size() - b0 != 5) begin
      n_fail++;
      $display("FAIL range37_count: got %0d want 5", got.size() - b0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (got[b0+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL range37_beat%0d: got %h want %h", i, got[b0+i], exp_q[i]);
        end
      end
    end
    b0 = got.size();
    d0 = done_cnt;
    bz0 = busy_cnt;
    do_start(9, 4, n);
    repeat (6) @(posedge clk);
    #1;
    n_chk++;
    if (got.size() != b0 || busy_cnt != bz0) begin
      n_fail++;
      $display("FAIL empty_range: got beats=%0d busy=%0d want 0/0",
               got.size() - b0, busy_cnt - bz0);
    end
    n_chk++;
    if (done_cnt - d0 != 1 || last_done_edge != n) begin
      n_fail++;
      $display("FAIL empty_done: got pulses=%0d edge=%0d want 1/%0d",
               done_cnt - d0, last_done_edge, n);
    end
    b0 = got.size();
    d0 = done_cnt;
    build_exp(31, 31);
    do_start(31, 31, n);
    run_until_done(1'b0, d0);
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (got.size() - b0 != 1 || got[b0] !== exp_q[0] || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL range31_single: got %0d beats busy=%b want 1 beat %h",
               got.size() - b0, busy, exp_q[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int n, b0, d0;
    bit seen = 1'b0;
    b0 = got.size();
    d0 = done_cnt;
    build_exp(0, 31);
    do_start(0, 31, n);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (m_valid && m_index == 4) seen = 1'b1;
    end
    start = 1'b1;
    first_idx = 5'd10;
    last_idx = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done(1'b0, d0);
    n_chk++;
    if (got.size() - b0 != 32) begin
      n_fail++;
      $display("FAIL busy_start_count: got %0d want 32", got.size() - b0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_chk++;
        if (got[b0+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL busy_start_beat%0d: got %h want %h", i, got[b0+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int n, b0, d0;
    bit seen = 1'b0;
    b0 = got.size();
    d0 = done_cnt;
    do_start(0, 31, n);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (m_valid && m_index == 12) seen = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (!seen || {rf_addr, m_valid, m_data, m_index, m_last, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got addr=%0h v=%b d=%0h i=%0h l=%b b=%b dn=%b want all 0",
               rf_addr, m_valid, m_data, m_index, m_last, busy, done);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (done_cnt != d0 || got.size() - b0 != 12) begin
      n_fail++;
      $display("FAIL abort_no_done: got done=%0d beats=%0d want 0/12",
               done_cnt - d0, got.size() - b0);
    end
    b0 = got.size();
    build_exp(0, 2);
    do_start(0, 2, n);
    run_until_done(1'b0, d0);
    n_chk++;
    if (got.size() - b0 != 3 || got[b0] !== exp_q[0] ||
        got[b0+1] !== exp_q[1] || got[b0+2] !== exp_q[2]) begin
      n_fail++;
      $display("FAIL after_reset_dump: got %0d beats want 3 matching", got.size() - b0);
    end
  endtask

  task automatic test_coherency();
    int n, b0, d0;
    bit seen = 1'b0;
    b0 = got.size();
    d0 = done_cnt;
    build_exp(0, 31);
    exp_q[20].data = 32'hDEADBEEF;
    do_start(0, 31, n);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (m_valid && m_index == 10) seen = 1'b1;
    end
    we = 1'b1; wa = 5'd20; wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    wa = 5'd2; wd = 32'h0;
    @(posedge clk); #1;
    we = 1'b0;
    run_until_done(1'b0, d0);
    n_chk++;
    if (got.size() - b0 != 32) begin
      n_fail++;
      $display("FAIL coh_count: got %0d want 32", got.size() - b0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_chk++;
        if (got[b0+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL coh_beat%0d: got %h want %h", i, got[b0+i], exp_q[i]);
        end
      end
    end
    img[20] = 32'hDEADBEEF;
    img[2] = 32'h0;
  endtask

  task automatic test_random();
    int n, b0, d0, f, l, t;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 32; i++) img[i] = $urandom;
      load_rf();
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      if (f > l) begin t = f; f = l; l = t; end
      b0 = got.size();
      d0 = done_cnt;
      build_exp(f, l);
      do_start(f, l, n);
      run_until_done(1'b1, d0);
      n_chk++;
      if (got.size() - b0 != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d want %0d", it,
                 got.size() - b0, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_chk++;
          if (got[b0+i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand%0d_beat%0d: got %h want %h", it, i,
                     got[b0+i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_ranges();
    test_start_while_busy();
    test_reset_mid_dump();
    test_coherency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
